// File: rtl/line_xfer_initiator.sv
// Cache-line initiator: splits one refill/write-back into WORDS_PER_LINE strobe/done
// word transactions, assembling read words into a line buffer, with a response watchdog.
module line_xfer_initiator #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_i,
  input  logic                                 req_rw_i,
  input  logic [ADDR_WIDTH-1:0]                req_addr_i,
  input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] req_wline_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] rline_o,
  output logic                                 strobe_o,
  output logic [ADDR_WIDTH-1:0]                addr_o,
  output logic [DATA_WIDTH-1:0]                wdata_o,
  output logic                                 rw_o,
  input  logic [DATA_WIDTH-1:0]                rdata_i,
  input  logic                                 done_i
);

  localparam int unsigned LW  = DATA_WIDTH * WORDS_PER_LINE;
  localparam int unsigned WB  = DATA_WIDTH / 8;
  localparam int unsigned OFF = $clog2(WB * WORDS_PER_LINE);
  localparam int unsigned BSH = $clog2(WB);
  localparam int unsigned IW  = $clog2(WORDS_PER_LINE);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, idx_inc;
  logic [TW-1:0]         timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [LW-1:0]         wline_q, wline_d, rline_q, rline_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, next_word;
  logic                  rw_q, rw_d, busy_q, busy_d, done_q, done_d;
  logic                  err_q, err_d, strobe_q, strobe_d;

  // Write word for the next index, selected from the latched line
  always_comb begin
    idx_inc   = idx_q + IW'(1);
    next_word = '0;
    for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
      if (IW'(i) == idx_inc) next_word = wline_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next state; outputs are computed against the next state so they register in step with it
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    base_d   = base_q;
    wline_d  = wline_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rline_d  = rline_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          rw_d     = req_rw_i;
          base_d   = req_addr_i & ~OFF_MASK;
          wline_d  = req_wline_i;
          idx_d    = '0;
          state_d  = S_ISSUE;
          strobe_d = 1'b1;
          addr_d   = req_addr_i & ~OFF_MASK;
          wdata_d  = req_rw_i ? req_wline_i[DATA_WIDTH-1:0] : '0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        // done_i takes priority over a simultaneous watchdog expiry
        if (done_i) begin
          if (!rw_q) begin
            for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
              if (IW'(i) == idx_q) rline_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata_i;
            end
          end
          if (idx_q == IW'(WORDS_PER_LINE - 1)) begin
            state_d = S_RESP;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_inc;
            state_d  = S_ISSUE;
            strobe_d = 1'b1;
            addr_d   = base_q | (ADDR_WIDTH'(idx_inc) << BSH);
            wdata_d  = rw_q ? next_word : '0;
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      base_q   <= '0;
      wline_q  <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rline_q  <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      base_q   <= base_d;
      wline_q  <= wline_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rline_q  <= rline_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign rline_o  = rline_q;
  assign strobe_o = strobe_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign rw_o     = rw_q;

endmodule

// File: tb/tb_line_xfer_initiator.sv
// Bench for line_xfer_initiator: directed protocol cases plus random line transfers
// against a line-level memory model and a configurable-latency word responder.
module tb_line_xfer_initiator;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned WPL = 4;
  localparam int unsigned TO  = 16;
  localparam int unsigned LW  = DW * WPL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_i, req_rw_i;
  logic [AW-1:0] req_addr_i;
  logic [LW-1:0] req_wline_i;
  logic          busy_o, done_o, err_o, strobe_o, rw_o;
  logic [LW-1:0] rline_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_i;
  logic          done_i;

  int n_chk = 0;
  int n_err = 0;

  line_xfer_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_rw_i(req_rw_i),
    .req_addr_i(req_addr_i), .req_wline_i(req_wline_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rline_o(rline_o),
    .strobe_o(strobe_o), .addr_o(addr_o), .wdata_o(wdata_o), .rw_o(rw_o),
    .rdata_i(rdata_i), .done_i(done_i)
  );

  always #5 clk = ~clk;

  // Responder memory (written only by the responder) and its read-only preload
  logic [DW-1:0] mem      [logic [AW-1:0]];
  logic [DW-1:0] init_mem [logic [AW-1:0]];
  // Reference memory seen at the line level
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];
  logic [LW-1:0] exp_line;

  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_wdata[$];
  logic          q_rw[$];
  int            lat_cfg    = 0;
  int            silent_cfg = -1;
  bit            spur_done  = 1'b0;
  int            stab_viol  = 0;
  bit            pending    = 1'b0;
  int            cnt        = 0;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic          p_rw;

  // Word responder: answers lat_cfg cycles into WAIT, stays silent on strobe index silent_cfg
  always begin
    @(posedge clk);
    #1;
    done_i  = spur_done;
    rdata_i = $urandom;
    if (pending) begin
      if (cnt == 0) begin
        done_i  = 1'b1;
        pending = 1'b0;
        if (p_rw) mem[p_addr] = p_wdata;
        else if (mem.exists(p_addr)) rdata_i = mem[p_addr];
        else if (init_mem.exists(p_addr)) rdata_i = init_mem[p_addr];
        else rdata_i = '0;
      end else begin
        cnt--;
      end
    end
    if (strobe_o === 1'b1) begin
      if (q_addr.size() != silent_cfg) begin
        pending = 1'b1;
        cnt     = lat_cfg;
      end
      p_addr  = addr_o;
      p_wdata = wdata_o;
      p_rw    = rw_o;
      q_addr.push_back(addr_o);
      q_wdata.push_back(wdata_o);
      q_rw.push_back(rw_o);
    end else if (busy_o === 1'b1 && done_o === 1'b0) begin
      if (addr_o !== p_addr || wdata_o !== p_wdata || rw_o !== p_rw) stab_viol++;
    end
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_mem[a] = d;
    ref_mem[a]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One line transfer; silent>=0 names the word the responder never answers
  task automatic xfer(input logic rw, input logic [AW-1:0] addr, input logic [LW-1:0] wl,
                      input int lat, input int silent, input bit hold, input string tag);
    int            start, s0, n_exp, n_ok, cyc, exp_cyc, busy_bad;
    bit            exp_err;
    logic [AW-1:0] base;
    logic [DW-1:0] ew;
    base       = addr & ~AW'(WPL * DW / 8 - 1);
    start      = q_addr.size();
    s0         = stab_viol;
    lat_cfg    = lat;
    silent_cfg = (silent < 0) ? -1 : start + silent;
    exp_err    = (silent >= 0);
    n_ok       = exp_err ? silent : WPL;
    n_exp      = exp_err ? silent + 1 : WPL;
    exp_cyc    = exp_err ? 1 + silent * (lat + 2) + TO + 1 : 1 + WPL * (lat + 2);
    for (int i = 0; i < n_ok; i++) begin
      if (rw) ref_mem[base + AW'(4 * i)] = wl[i*DW +: DW];
      else exp_line[i*DW +: DW] = ref_rd(base + AW'(4 * i));
    end

    req_i       = 1'b1;
    req_rw_i    = rw;
    req_addr_i  = addr;
    req_wline_i = wl;
    cyc         = 0;
    busy_bad    = 0;
    while (cyc < 400) begin
      tick();
      cyc++;
      if (!hold) req_i = 1'b0;
      req_addr_i  = $urandom;
      req_wline_i = {$urandom, $urandom, $urandom, $urandom};
      if (busy_o !== 1'b1) busy_bad++;
      if (done_o === 1'b1) break;
    end
    req_i = 1'b0;
    chk($sformatf("%s_latency", tag), LW'(cyc), LW'(exp_cyc));
    chk($sformatf("%s_err", tag), LW'(err_o), LW'(exp_err));
    chk($sformatf("%s_busy_during", tag), LW'(busy_bad), LW'(0));
    tick();
    chk($sformatf("%s_busy_after", tag), LW'(busy_o), LW'(0));
    chk($sformatf("%s_done_pulse", tag), LW'(done_o), LW'(0));
    repeat (3) tick();
    chk($sformatf("%s_strobes", tag), LW'(q_addr.size() - start), LW'(n_exp));
    for (int i = 0; i < n_exp && start + i < q_addr.size(); i++) begin
      ew = rw ? wl[i*DW +: DW] : '0;
      chk($sformatf("%s_addr%0d", tag, i), LW'(q_addr[start+i]), LW'(base + AW'(4 * i)));
      chk($sformatf("%s_rw%0d", tag, i), LW'(q_rw[start+i]), LW'(rw));
      chk($sformatf("%s_wdata%0d", tag, i), LW'(q_wdata[start+i]), LW'(ew));
    end
    chk($sformatf("%s_rline", tag), rline_o, exp_line);
    chk($sformatf("%s_stable", tag), LW'(stab_viol - s0), LW'(0));
  endtask

  initial begin
    int            n0, bad, start;
    logic [LW-1:0] line_snap;
    rst_n       = 1'b0;
    req_i       = 1'b0;
    req_rw_i    = 1'b0;
    req_addr_i  = '0;
    req_wline_i = '0;
    exp_line    = '0;
    repeat (3) tick();
    chk("rst_busy", LW'(busy_o), LW'(0));
    chk("rst_done", LW'(done_o), LW'(0));
    chk("rst_err", LW'(err_o), LW'(0));
    chk("rst_strobe", LW'(strobe_o), LW'(0));
    chk("rst_rw", LW'(rw_o), LW'(0));
    chk("rst_addr", LW'(addr_o), LW'(0));
    chk("rst_wdata", LW'(wdata_o), LW'(0));
    chk("rst_rline", rline_o, LW'(0));
    rst_n = 1'b1;
    tick();

    // Refill of an unaligned address
    preload(32'h1030, 32'h11);
    preload(32'h1034, 32'h22);
    preload(32'h1038, 32'h33);
    preload(32'h103C, 32'h44);
    xfer(1'b0, 32'h0000_1038, '0, 0, -1, 1'b0, "t1");
    chk("t1_line_const", rline_o, 128'h00000044_00000033_00000022_00000011);

    // Write-back then readback
    xfer(1'b1, 32'h2000, 128'h0000000D_0000000C_0000000B_0000000A, 0, -1, 1'b0, "t2w");
    xfer(1'b0, 32'h2004, '0, 0, -1, 1'b0, "t2r");
    chk("t2_line_const", rline_o, 128'h0000000D_0000000C_0000000B_0000000A);

    // Slow responder
    xfer(1'b0, 32'h1030, '0, 8, -1, 1'b0, "t3r");
    xfer(1'b1, 32'h2010, 128'h44444444_33333333_22222222_11111111, 8, -1, 1'b0, "t3w");
    xfer(1'b0, 32'h2000, '0, 0, -1, 1'b0, "t4pre");

    // Watchdog on word 2: words 0,1 refreshed, 2,3 keep the previous line
    xfer(1'b0, 32'h103C, '0, 0, 2, 1'b0, "t4");
    chk("t4_line_const", rline_o, 128'h0000000D_0000000C_00000022_00000011);

    // Request held high, then spurious done_i while idle
    xfer(1'b0, 32'h1030, '0, 1, -1, 1'b1, "t5");
    n0        = q_addr.size();
    line_snap = exp_line;
    bad       = 0;
    spur_done = 1'b1;
    repeat (4) begin
      tick();
      if (busy_o !== 1'b0 || strobe_o !== 1'b0) bad++;
    end
    spur_done = 1'b0;
    repeat (2) tick();
    chk("t5_spur_idle", LW'(bad), LW'(0));
    chk("t5_spur_strobes", LW'(q_addr.size() - n0), LW'(0));
    chk("t5_spur_rline", rline_o, line_snap);

    // Reset while waiting on word 1
    start      = q_addr.size();
    lat_cfg    = 8;
    silent_cfg = -1;
    req_i      = 1'b1;
    req_rw_i   = 1'b0;
    req_addr_i = 32'h2000;
    tick();
    req_i = 1'b0;
    n0    = 0;
    while (q_addr.size() < start + 2 && n0 < 100) begin
      tick();
      n0++;
    end
    chk("t6_word1_issued", LW'(q_addr.size() - start), LW'(2));
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("t6_rst_busy", LW'(busy_o), LW'(0));
    chk("t6_rst_strobe", LW'(strobe_o), LW'(0));
    chk("t6_rst_addr", LW'(addr_o), LW'(0));
    chk("t6_rst_rline", rline_o, LW'(0));
    rst_n    = 1'b1;
    exp_line = '0;
    repeat (12) tick();
    chk("t6_discard_busy", LW'(busy_o), LW'(0));
    chk("t6_discard_rline", rline_o, LW'(0));
    xfer(1'b0, 32'h2008, '0, 0, -1, 1'b0, "t6");

    // Random transfers over a small region so reads observe earlier writes
    for (int k = 0; k < 25; k++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] wl;
      int            sil;
      a   = 32'h4000 + AW'($urandom_range(0, 7) << 4) + AW'($urandom_range(0, 15));
      wl  = {$urandom, $urandom, $urandom, $urandom};
      sil = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WPL - 1)) : -1;
      xfer(1'($urandom_range(0, 1)), a, wl, int'($urandom_range(0, 4)), sil,
           1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
